// File: rtl/pragmatic_term_scheduler.sv
// Pragmatic MAC weight-side term scheduler.
// Breaks each lane weight into sign-magnitude power-of-two terms and emits one
// beat per MAC cycle. A beat has a shared base shift and per-lane offsets from
// that base.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no vector held; in_ready=1, out_valid=0
// EMIT  | a registered beat is on the outputs; waits for out_ready
module pragmatic_term_scheduler #(
   parameter int DATA_WIDTH   = 8,
   parameter int VEC_LENGTH   = 8,
   parameter int OFFSET_RANGE = 4
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [DATA_WIDTH*VEC_LENGTH-1:0]         weight,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic                                     out_last,
   output logic [$clog2(OFFSET_RANGE)*VEC_LENGTH-1:0] shift_1st_sel,
   output logic [VEC_LENGTH-1:0]                    shift_1st_en,
   output logic [VEC_LENGTH-1:0]                    is_neg,
   output logic [$clog2(DATA_WIDTH)-1:0]            shift_2nd_sel,
   output logic                                     shift_2nd_en
);

   localparam int OW = $clog2(OFFSET_RANGE);
   localparam int SW = $clog2(DATA_WIDTH);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t state_q, state_d;
   logic   accept, advance, go_idle;

   logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_lane, w_mag;
   logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] mask_q, src_mask, rem_mask;
   logic [VEC_LENGTH-1:0]                 neg_q, src_neg;
   logic [DATA_WIDTH-1:0]                 any_mask;
   logic [SW-1:0]                         base;
   logic [VEC_LENGTH-1:0][SW-1:0]         low_pos, diff;
   logic [VEC_LENGTH-1:0]                 beat_en, beat_neg;
   logic [VEC_LENGTH-1:0][OW-1:0]         beat_sel;
   logic                                  beat_any, beat_last;

   logic [VEC_LENGTH-1:0][OW-1:0]         sel1_q;
   logic [VEC_LENGTH-1:0]                 en1_q, neg_out_q;
   logic [SW-1:0]                         sel2_q;
   logic                                  en2_q, last_q;

   assign w_lane = weight;

   // Magnitude of each incoming weight; -2^(N-1) maps to the lone MSB.
   always_comb begin
      w_mag = '0;
      for (int j = 0; j < VEC_LENGTH; j++) begin
         w_mag[j] = w_lane[j][DATA_WIDTH-1] ? (~w_lane[j] + DATA_WIDTH'(1)) : w_lane[j];
      end
   end

   // Beat source: fresh weights on acceptance, otherwise the remaining masks.
   always_comb begin
      src_mask = '0;
      src_neg  = '0;
      for (int j = 0; j < VEC_LENGTH; j++) begin
         src_mask[j] = accept ? w_mag[j] : mask_q[j];
         src_neg[j]  = accept ? w_lane[j][DATA_WIDTH-1] : neg_q[j];
      end
   end

   // Shared base = lowest remaining bit across all lanes.
   always_comb begin
      any_mask = '0;
      base     = '0;
      for (int j = 0; j < VEC_LENGTH; j++) begin
         any_mask = any_mask | src_mask[j];
      end
      for (int i = DATA_WIDTH-1; i >= 0; i--) begin
         if (any_mask[i]) base = SW'(i);
      end
      beat_any = |any_mask;
   end

   // Per-lane term: lowest remaining bit, emitted only if within offset reach.
   always_comb begin
      low_pos  = '0;
      diff     = '0;
      beat_en  = '0;
      beat_neg = '0;
      beat_sel = '0;
      rem_mask = '0;
      for (int j = 0; j < VEC_LENGTH; j++) begin
         for (int i = DATA_WIDTH-1; i >= 0; i--) begin
            if (src_mask[j][i]) low_pos[j] = SW'(i);
         end
         diff[j]     = low_pos[j] - base;
         beat_en[j]  = (|src_mask[j]) && (diff[j] < SW'(OFFSET_RANGE));
         beat_sel[j] = beat_en[j] ? diff[j][OW-1:0] : '0;
         beat_neg[j] = beat_en[j] & src_neg[j];
         rem_mask[j] = beat_en[j] ? (src_mask[j] & ~(DATA_WIDTH'(1) << low_pos[j]))
                                  : src_mask[j];
      end
      beat_last = (rem_mask == '0);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and handshake decode; a new vector may land on the last beat.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      accept   = 1'b0;
      advance  = 1'b0;
      go_idle  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (last_q) begin
                  in_ready = 1'b1;
                  if (in_valid) begin
                     accept = 1'b1;
                  end else begin
                     go_idle = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Beat register and remaining masks; masks only move when a beat is loaded.
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q    <= '0;
         neg_q     <= '0;
         sel1_q    <= '0;
         en1_q     <= '0;
         neg_out_q <= '0;
         sel2_q    <= '0;
         en2_q     <= 1'b0;
         last_q    <= 1'b0;
      end else if (accept || advance) begin
         mask_q    <= rem_mask;
         neg_q     <= src_neg;
         sel1_q    <= beat_sel;
         en1_q     <= beat_en;
         neg_out_q <= beat_neg;
         sel2_q    <= base;
         en2_q     <= beat_any;
         last_q    <= beat_last;
      end else if (go_idle) begin
         sel1_q    <= '0;
         en1_q     <= '0;
         neg_out_q <= '0;
         sel2_q    <= '0;
         en2_q     <= 1'b0;
         last_q    <= 1'b0;
      end
   end

   assign out_valid     = (state_q == EMIT);
   assign out_last      = last_q;
   assign shift_1st_sel = sel1_q;
   assign shift_1st_en  = en1_q;
   assign is_neg        = neg_out_q;
   assign shift_2nd_sel = sel2_q;
   assign shift_2nd_en  = en2_q;

endmodule
